// File: rtl/icache_refill_pkg.sv
// Shared types for the instruction-cache refill engine: refill FSM
// states, bus widths and the byte-slot helper used by the collector.
package icache_refill_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int INDEX_W_DEF = 7;
    localparam int BYTE_W      = 8;
    localparam int WORD_W      = 32;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_WAIT,
        S_FILL
    } refill_state_t;

    // Memory returns a byte one cycle after its address, so the slot
    // being written is always one behind the issue counter. In WAIT the
    // counter has wrapped to 0, which lands byte 3 in slot 3.
    function automatic logic [1:0] prev_slot(input logic [1:0] cnt);
        return cnt - 2'd1;
    endfunction

endpackage

// File: rtl/icache_refill_byte_collector.sv
// Byte counter and little-endian word assembly for one refill.
// Ports: clk, rst (sync, active-high); i_clear resets the counter;
//  i_issue advances it; i_sample stores i_byte in the slot one behind
//  the counter; o_cnt is the byte offset being issued; o_last flags
//  the final byte; o_word is the assembled instruction.
module icache_refill_byte_collector
    import icache_refill_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_issue,
    input  logic        i_sample,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_cnt,
    output logic        o_last,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    word_t       r_word;
    logic [1:0]  w_slot;

    assign w_slot = prev_slot(r_cnt);
    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == 2'd3);
    assign o_word = r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 2'd0;
            r_word <= '0;
        end else begin
            if (i_clear)
                r_cnt <= 2'd0;
            else if (i_issue)
                r_cnt <= r_cnt + 2'd1;
            if (i_sample)
                r_word[{w_slot, 3'b000} +: BYTE_W] <= i_byte;
        end
    end

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache miss handler: fetches the missing word byte by byte
// over the shared memory bus, writes it into the cache, returns it.
// Ports: clk, rst (sync, active-high); miss_valid/miss_addr/flush from
//  fetch; inst_valid/inst_data back to fetch; arb_req/arb_gnt to the
//  arbiter; mem_a/mem_wr/mem_din byte bus; write_bit/write_index/
//  write_tag/write_data cache write port.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        miss_valid,
    input  logic [ADDR_W-1:0]           miss_addr,
    input  logic                        flush,
    output logic                        inst_valid,
    output logic [31:0]                 inst_data,
    output logic                        arb_req,
    input  logic                        arb_gnt,
    output logic [ADDR_W-1:0]           mem_a,
    output logic                        mem_wr,
    input  logic [7:0]                  mem_din,
    output logic                        write_bit,
    output logic [INDEX_W-1:0]          write_index,
    output logic [ADDR_W-INDEX_W-3:0]   write_tag,
    output logic [31:0]                 write_data
);

    localparam int WA_W  = ADDR_W - 2;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    refill_state_t       r_state;
    refill_state_t       w_state_nxt;
    logic [WA_W-1:0]     r_addr;
    logic                r_arb_req;
    logic                r_inst_valid;
    logic                r_write_bit;
    word_t               r_inst_data;
    logic [INDEX_W-1:0]  r_write_index;
    logic [TAG_W-1:0]    r_write_tag;

    logic                w_accept;
    logic                w_clear;
    logic                w_issue;
    logic                w_sample;
    logic                w_fill;
    logic                w_req_nxt;
    logic                w_valid_nxt;
    logic [ADDR_W-1:0]   w_mem_a;
    logic [1:0]          w_cnt;
    logic                w_last;
    word_t               w_word;
    logic                w_unused_lsb;

    assign w_unused_lsb = &{1'b0, miss_addr[1:0]};

    // The requester may still hold miss_valid while the result pulse is
    // out; the word is in the cache by then, so that is not a new miss.
    assign w_accept = (r_state == S_IDLE) && miss_valid && !flush &&
                      !r_inst_valid && !r_write_bit;

    icache_refill_byte_collector u_collector (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_issue  (w_issue),
        .i_sample (w_sample),
        .i_byte   (mem_din),
        .o_cnt    (w_cnt),
        .o_last   (w_last),
        .o_word   (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (flush)
                    w_state_nxt = S_IDLE;
                else if (arb_gnt)
                    w_state_nxt = S_READ;
            end
            S_READ: begin
                if (flush)
                    w_state_nxt = S_IDLE;
                else if (w_last)
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_state_nxt = flush ? S_IDLE : S_FILL;
            end
            S_FILL: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_clear     = (r_state == S_REQ);
        w_issue     = (r_state == S_READ);
        w_sample    = ((r_state == S_READ) && (w_cnt != 2'd0)) ||
                      (r_state == S_WAIT);
        w_fill      = (r_state == S_FILL);
        // A flush during FILL still commits the write: the bytes are
        // genuine memory contents, only the fetch response is dropped.
        w_valid_nxt = w_fill && !flush;
        w_req_nxt   = (w_state_nxt == S_REQ) || (w_state_nxt == S_READ);
        w_mem_a     = '0;
        if (r_state == S_READ)
            w_mem_a = {r_addr, w_cnt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr        <= '0;
            r_arb_req     <= 1'b0;
            r_inst_valid  <= 1'b0;
            r_write_bit   <= 1'b0;
            r_inst_data   <= '0;
            r_write_index <= '0;
            r_write_tag   <= '0;
        end else begin
            if (w_accept)
                r_addr <= miss_addr[ADDR_W-1:2];
            r_arb_req    <= w_req_nxt;
            r_inst_valid <= w_valid_nxt;
            r_write_bit  <= w_fill;
            if (w_fill) begin
                r_inst_data   <= w_word;
                r_write_index <= r_addr[INDEX_W-1:0];
                r_write_tag   <= r_addr[WA_W-1:INDEX_W];
            end
        end
    end

    assign inst_valid  = r_inst_valid;
    assign inst_data   = r_inst_data;
    assign arb_req     = r_arb_req;
    assign mem_a       = w_mem_a;
    assign mem_wr      = 1'b0;
    assign write_bit   = r_write_bit;
    assign write_index = r_write_index;
    assign write_tag   = r_write_tag;
    assign write_data  = r_inst_data;

endmodule

// File: tb/tb_icache_refill.sv
// Directed and randomized refills checked against a timing/memory
// reference model derived from the refill latency and flush rules.
module tb_icache_refill;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        arb_req;
    logic        arb_gnt;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        write_bit;
    logic [6:0]  write_index;
    logic [22:0] write_tag;
    logic [31:0] write_data;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mem [logic [31:0]];
    logic       pend;
    logic [31:0] pend_a;

    always #5 clk = ~clk;

    icache_refill dut (
        .clk         (clk),
        .rst         (rst),
        .miss_valid  (miss_valid),
        .miss_addr   (miss_addr),
        .flush       (flush),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .arb_req     (arb_req),
        .arb_gnt     (arb_gnt),
        .mem_a       (mem_a),
        .mem_wr      (mem_wr),
        .mem_din     (mem_din),
        .write_bit   (write_bit),
        .write_index (write_index),
        .write_tag   (write_tag),
        .write_data  (write_data)
    );

    function automatic logic [7:0] mb(input logic [31:0] a);
        if (!mem.exists(a))
            mem[a] = 8'($urandom);
        return mem[a];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory answers one cycle after the address; otherwise junk.
    task automatic mem_step();
        mem_din = pend ? mb(pend_a) : 8'($urandom);
        pend    = (mem_a != 32'd0);
        pend_a  = mem_a;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(inst_valid), 64'd0);
        chk({tag, "_wbit"}, 64'(write_bit), 64'd0);
        chk({tag, "_req"}, 64'(arb_req), 64'd0);
        chk({tag, "_mema"}, 64'(mem_a), 64'd0);
        chk({tag, "_memwr"}, 64'(mem_wr), 64'd0);
        chk({tag, "_idata"}, 64'(inst_data), 64'd0);
        chk({tag, "_wdata"}, 64'(write_data), 64'd0);
        chk({tag, "_widx"}, 64'(write_index), 64'd0);
        chk({tag, "_wtag"}, 64'(write_tag), 64'd0);
    endtask

    // Cycle 0 presents the miss; grant is seen in cycle g = 1 + dly.
    // Bytes go out in g+1..g+4, result pulses in g+7. f / r give the
    // cycle in which flush / reset is driven (-1 for none).
    task automatic refill(input string tag, input logic [31:0] addr,
                          input int dly, input int f, input int r);
        int          g    = 1 + dly;
        int          stop = (f >= 0) ? f : ((r >= 0) ? r : 1000);
        logic [31:0] base = {addr[31:2], 2'b00};
        logic [31:0] word;
        logic        abort;
        logic        vld;
        logic        exp_req;
        logic [31:0] exp_a;
        word  = {mb(base + 3), mb(base + 2), mb(base + 1), mb(base)};
        abort = (f >= 0 && f <= g + 5) || (r >= 0 && r <= g + 6);
        vld   = !abort && (f != g + 6);
        for (int n = 0; n <= g + 9; n++) begin
            @(negedge clk);
            mem_step();
            exp_req = (n >= 1) && (n <= g + 4) && (n <= stop);
            exp_a   = (n >= g + 1 && n <= g + 4 && n <= stop) ?
                      base + 32'(n - g - 1) : 32'd0;
            chk({tag, "_req"}, 64'(arb_req), 64'(exp_req));
            chk({tag, "_mema"}, 64'(mem_a), 64'(exp_a));
            chk({tag, "_memwr"}, 64'(mem_wr), 64'd0);
            if (n == g + 7) begin
                chk({tag, "_wbit"}, 64'(write_bit), 64'(!abort));
                chk({tag, "_valid"}, 64'(inst_valid), 64'(vld));
                if (!abort) begin
                    chk({tag, "_wdata"}, 64'(write_data), 64'(word));
                    chk({tag, "_widx"}, 64'(write_index),
                        64'((base >> 2) & 32'h7F));
                    chk({tag, "_wtag"}, 64'(write_tag), 64'(base >> 9));
                end
                if (vld)
                    chk({tag, "_idata"}, 64'(inst_data), 64'(word));
            end else begin
                chk({tag, "_wbit"}, 64'(write_bit), 64'd0);
                chk({tag, "_valid"}, 64'(inst_valid), 64'd0);
            end
            if (r >= 0 && n == r + 1)
                chk_all_zero({tag, "_rst"});
            miss_valid = (n <= g + 7) && (n < stop);
            miss_addr  = (n == 0) ? addr : $urandom;
            arb_gnt    = (n >= g) && (n <= g + 4);
            flush      = (n == f);
            rst        = (n == r);
        end
        miss_valid = 1'b0;
        arb_gnt    = 1'b0;
        flush      = 1'b0;
        rst        = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          dly;
        int          sel;
        int          f;
        int          r;
        rst        = 1'b1;
        miss_valid = 1'b0;
        miss_addr  = 32'd0;
        flush      = 1'b0;
        arb_gnt    = 1'b0;
        mem_din    = 8'd0;
        pend       = 1'b0;
        pend_a     = 32'd0;
        mem[32'h1000] = 8'h13;
        mem[32'h1001] = 8'h05;
        mem[32'h1002] = 8'h00;
        mem[32'h1003] = 8'h00;

        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        mem_step();

        refill("zero_wait", 32'h0000_1002, 0, -1, -1);
        refill("gnt_delay", 32'h0000_4A11, 5, -1, -1);
        refill("flush_read", 32'h0000_5004, 0, 3, -1);
        refill("after_flush", 32'h0000_2000, 0, -1, -1);
        refill("flush_fill", 32'h0000_6008, 1, 8, -1);
        refill("refetch", 32'h0000_6008, 0, -1, -1);
        refill("rst_wait", 32'h0000_700C, 0, -1, 6);

        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            mem_step();
            if (n >= 1) begin
                chk("flush_idle_req", 64'(arb_req), 64'd0);
                chk("flush_idle_mema", 64'(mem_a), 64'd0);
            end
            miss_valid = (n < 3);
            flush      = (n < 3);
            miss_addr  = 32'h0000_3000;
        end

        refill("wrap_lo", 32'h0000_01FC, 0, -1, -1);
        refill("wrap_hi", 32'h0000_81FC, 2, -1, -1);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            if (a[31:2] == 30'd0)
                a = 32'h0000_0004;
            dly = $urandom_range(0, 4);
            sel = $urandom_range(0, 3);
            f   = (sel == 1) ? $urandom_range(1, dly + 7) : -1;
            r   = (sel == 2) ? $urandom_range(1, dly + 7) : -1;
            refill("random", a, dly, f, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
